// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared sizing, state encoding and block-offset helpers for the memory arbiter
package mem_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BLK_WORDS = 8;
  localparam int IDX_W = $clog2(BLK_WORDS);
  function automatic int blk_mask(input int words);
    return words * 2 - 1;
  endfunction
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(blk_mask(BLK_WORDS));
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    I_FILL  = 2'b01,
    D_FILL  = 2'b10,
    D_STORE = 2'b11
  } state_t;
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, fill-return and main-memory signals around the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = mem_arbiter_pkg::DATA_W,
  parameter int BLK_WORDS = mem_arbiter_pkg::BLK_WORDS
);
  localparam int IDX_W = $clog2(BLK_WORDS);
  logic i_req;
  logic [ADDR_W-1:0] i_addr;
  logic d_req;
  logic d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic i_fill_valid;
  logic d_fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0] fill_idx;
  logic i_done;
  logic d_done;
  logic mem_en;
  logic mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_rvalid;
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_fill_valid, d_fill_valid, fill_data, fill_idx, i_done, d_done,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_fill_valid, d_fill_valid, fill_data, fill_idx, i_done, d_done,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_fill_counter.sv
// mem_arbiter_fill_counter: word issue/return counters for one block fill
module mem_arbiter_fill_counter #(
  parameter int BLK_WORDS = 8,
  localparam int IDX_W = $clog2(BLK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             issue_en,
  input  logic             ret_en,
  output logic [IDX_W-1:0] issue_cnt,
  output logic [IDX_W-1:0] ret_cnt,
  output logic             issue_done,
  output logic             ret_last
);
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
    end else begin
      if (issue_en) begin
        issue_cnt  <= issue_cnt + 1'b1;
        issue_done <= issue_cnt == IDX_W'(BLK_WORDS - 1);
      end
      if (ret_en) ret_cnt <= ret_cnt + 1'b1;
    end
  end
  assign ret_last = ret_cnt == IDX_W'(BLK_WORDS - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main-memory port between I-cache fills and D-cache fills/stores
module mem_arbiter #(
  parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = mem_arbiter_pkg::DATA_W,
  parameter int BLK_WORDS = mem_arbiter_pkg::BLK_WORDS
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  import mem_arbiter_pkg::*;
  localparam int idx_w = $clog2(BLK_WORDS);
  localparam logic [ADDR_W-1:0] blk_off = ADDR_W'(blk_mask(BLK_WORDS));
  state_t state, state_nxt;
  grant_t last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [idx_w-1:0] issue_cnt, ret_cnt;
  logic issue_done, ret_last, grant_d, grant_i, fill, store, issuing, ret;
  mem_arbiter_fill_counter #(.BLK_WORDS(BLK_WORDS)) u_fill_counter (
    .clk(clk),
    .rst(rst),
    .clr(!fill),
    .issue_en(issuing),
    .ret_en(ret),
    .issue_cnt(issue_cnt),
    .ret_cnt(ret_cnt),
    .issue_done(issue_done),
    .ret_last(ret_last)
  );
  // D wins a tie unless it also won the previous grant
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || last_grant == GRANT_I);
    grant_i = bus.i_req && !grant_d;
    fill = state == I_FILL || state == D_FILL;
    store = state == D_STORE;
    issuing = fill && !issue_done;
    ret = fill && bus.mem_rvalid;
    state_nxt = state;
    if (state == IDLE) state_nxt = grant_d ? (bus.d_wr ? D_STORE : D_FILL) : grant_i ? I_FILL : IDLE;
    else if (store || (ret && ret_last)) state_nxt = IDLE;
  end
  always_comb begin
    bus.mem_en = issuing || store;
    bus.mem_wr = store;
    bus.mem_addr = store ? {addr_q[ADDR_W-1:1], 1'b0}
                 : issuing ? (addr_q & ~blk_off) | (ADDR_W'(issue_cnt) << 1) : '0;
    bus.mem_wdata = store ? wdata_q : '0;
    bus.i_fill_valid = ret && state == I_FILL;
    bus.d_fill_valid = ret && state == D_FILL;
    bus.fill_data = ret ? bus.mem_rdata : '0;
    bus.fill_idx = ret ? ret_cnt : '0;
    bus.i_done = ret && state == I_FILL && ret_last;
    bus.d_done = store || (ret && state == D_FILL && ret_last);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_d) begin
        last_grant <= GRANT_D;
        addr_q     <= bus.d_addr;
        wdata_q    <= bus.d_wdata;
      end else if (state == IDLE && grant_i) begin
        last_grant <= GRANT_I;
        addr_q     <= bus.i_addr;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench around a latency-4 pipelined memory model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  typedef struct {
    logic       is_d;
    logic [2:0] idx;
    logic [15:0] data;
    logic       last;
  } fill_t;
  typedef struct {
    logic       wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inj = 1'b0;
  logic b2b = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  fill_t exp_fill[$];
  txn_t exp_txn[$];
  logic [16:0] pipe [3];
  logic busy = 1'b0;
  logic armed = 1'b0;
  int k = 0;
  int done_cyc = 0;
  logic [15:0] base = '0;
  int n;
  mem_arbiter_if bus ();
  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction
  function automatic logic [63:0] outs();
    return 64'({bus.i_fill_valid, bus.d_fill_valid, bus.fill_data, bus.fill_idx, bus.i_done,
                bus.d_done, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata});
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push_fill(input bit is_d, input logic [15:0] b, input int cnt);
    exp_txn.push_back('{wr: 1'b0, addr: b, data: 16'h0000});
    for (int i = 0; i < cnt; i++)
      exp_fill.push_back('{is_d: is_d, idx: 3'(i), data: mem_fn(b + 16'(2 * i)), last: i == BLK_WORDS - 1});
  endtask
  task automatic push_store(input logic [15:0] a, input logic [15:0] d);
    exp_txn.push_back('{wr: 1'b1, addr: a, data: d});
  endtask
  task automatic wait_done(input bit is_d, input int max, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(is_d ? bus.d_done : bus.i_done) && cnt < max);
    check(is_d ? "d_done_seen" : "i_done_seen", is_d ? bus.d_done : bus.i_done, 1);
  endtask
  // Memory: a read issued in cycle t returns in cycle t+4; inj forces a stray return
  always @(posedge clk) begin
    if (!rst) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      pipe[0] <= {bus.mem_en && !bus.mem_wr, mem_fn(bus.mem_addr)};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      {bus.mem_rvalid, bus.mem_rdata} <= inj ? {1'b1, 16'hAAAA} : pipe[2];
    end
  end
  always @(negedge clk) begin : monitor
    fill_t f;
    txn_t t;
    if (!rst) begin
      busy = 1'b0;
      armed = 1'b0;
    end else begin
      if (bus.mem_en && !busy) begin
        if (armed) check("bubble", 64'(cyc - done_cyc), 2);
        armed = 1'b0;
        if (exp_txn.size() == 0) check("txn_unexpected", bus.mem_en, 0);
        else begin
          t = exp_txn.pop_front();
          check("txn_wr", bus.mem_wr, t.wr);
          check("txn_addr", bus.mem_addr, t.addr);
          if (t.wr) begin
            check("store_data", bus.mem_wdata, t.data);
            check("store_done", {bus.i_done, bus.d_done}, 2'b01);
          end
          busy = !t.wr;
          base = t.addr;
          k = 0;
        end
      end
      if (busy && bus.mem_en) begin
        check("issue_addr", bus.mem_addr, base + 16'(2 * k));
        k++;
      end
      if (bus.i_fill_valid || bus.d_fill_valid) begin
        if (exp_fill.size() == 0) check("fill_unexpected", {bus.i_fill_valid, bus.d_fill_valid}, 0);
        else begin
          f = exp_fill.pop_front();
          check("fill_src", {bus.i_fill_valid, bus.d_fill_valid}, f.is_d ? 2'b01 : 2'b10);
          check("fill_idx", bus.fill_idx, f.idx);
          check("fill_data", bus.fill_data, f.data);
          check("fill_done", {bus.i_done, bus.d_done}, f.last ? (f.is_d ? 2'b01 : 2'b10) : 2'b00);
        end
      end
      if (bus.i_done || bus.d_done) begin
        if (busy) check("issue_count", k, BLK_WORDS);
        busy = 1'b0;
        armed = b2b;
        done_cyc = cyc;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) step();
    check("reset_outputs", outs(), 0);
    rst = 1;
    step();
    push_store(16'h0404, 16'hBEEF);
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0405; bus.d_wdata = 16'hBEEF;
    wait_done(1, 5, n);
    check("store_latency", n, 1);
    bus.d_req = 0; bus.d_wr = 0;
    step();
    check("store_then_idle", outs(), 0);
    push_fill(0, 16'h1230, 8);
    bus.i_req = 1; bus.i_addr = 16'h1236;
    wait_done(0, 40, n);
    check("ifill_latency", n, 12);
    bus.i_req = 0;
    step();
    inj = 1;
    step();
    inj = 0;
    check("spur_valid", {bus.i_fill_valid, bus.d_fill_valid}, 0);
    check("spur_idx", bus.fill_idx, 0);
    check("spur_data", bus.fill_data, 0);
    push_fill(1, 16'h2000, 8);
    push_fill(0, 16'h3010, 8);
    push_fill(1, 16'h2120, 8);
    push_fill(0, 16'h4A70, 8);
    b2b = 1;
    bus.i_req = 1; bus.i_addr = 16'h3019;
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h2004;
    wait_done(1, 40, n);
    bus.d_addr = 16'h2128;
    wait_done(0, 40, n);
    bus.i_addr = 16'h4A7E;
    wait_done(1, 40, n);
    bus.d_req = 0; b2b = 0;
    wait_done(0, 40, n);
    bus.i_req = 0;
    step();
    push_store(16'h0A10, 16'h1111);
    push_fill(0, 16'h5000, 8);
    push_store(16'h0B22, 16'h2222);
    b2b = 1;
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0A11; bus.d_wdata = 16'h1111;
    bus.i_req = 1; bus.i_addr = 16'h5004;
    wait_done(1, 10, n);
    bus.d_addr = 16'h0B23; bus.d_wdata = 16'h2222;
    wait_done(0, 40, n);
    bus.i_req = 0; b2b = 0;
    wait_done(1, 10, n);
    bus.d_req = 0; bus.d_wr = 0; bus.d_wdata = '0;
    step();
    push_fill(1, 16'h6040, 4);
    bus.d_req = 1; bus.d_addr = 16'h6046;
    n = 0;
    do begin
      step();
      n++;
    end while (!(bus.d_fill_valid && bus.fill_idx == 3'd3) && n < 40);
    check("fourth_return_seen", bus.d_fill_valid, 1);
    rst = 0; bus.d_req = 0;
    step();
    check("midfill_reset_outputs", outs(), 0);
    check("midfill_fill_queue", exp_fill.size(), 0);
    rst = 1;
    push_fill(1, 16'h6040, 8);
    bus.d_req = 1;
    wait_done(1, 40, n);
    check("refill_latency", n, 12);
    bus.d_req = 0;
    repeat (5) step();
    check("fill_queue_empty", exp_fill.size(), 0);
    check("txn_queue_empty", exp_txn.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
